// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-type encodings and default widths.
package uart_pkg;
  localparam int UART_DATA_WIDTH     = 8;
  localparam int UART_PRESCALE_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches the prescale on load, treats 0 as 1, and pulses
// bit_tick on the last clock of every bit while enabled.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      load,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_tick
);
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic [PRESCALE_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    p_d       = p_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_tick  = en && (cyc_cnt_q == p_q - 1'b1);
    if (load) begin
      p_d       = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
      cyc_cnt_d = '0;
    end else if (!en || bit_tick) begin
      cyc_cnt_d = '0;
    end else begin
      cyc_cnt_d = cyc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      p_q       <= '0;
      cyc_cnt_q <= '0;
    end else begin
      p_q       <= p_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy,
  output logic                      Tx_Done
);
  localparam int BCW = $clog2(DATA_WIDTH);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_tick;
  logic                  stop_last;

  uart_bit_timer #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_timer (
    .gclk    (CLK),
    .grst_n  (RST),
    .load    (accept),
    .en      (busy_q),
    .prescale(Prescale),
    .bit_tick(bit_tick)
  );

  // bit_cnt is idle during STOP, so it doubles as the stop-bit counter.
`ifdef UART_TX_TWO_STOP_EN
  assign stop_last = (bit_cnt_q != '0);
`else
  assign stop_last = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          accept    = 1'b1;
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_d     = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: if (bit_tick) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_tick) begin
        if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
          bit_cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          // TX_OUT is registered, so it takes the bit the shift is about to expose.
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_d      = shift_q[1];
        end
      end
      PARITY: if (bit_tick) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_tick) begin
        if (stop_last) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          bit_cnt_d = BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign Busy    = busy_q;
  assign Tx_Done = done_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: per-cycle waveform comparison against a frame-level model.
module tb_uart_tx_core;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       CLK, RST, Data_Valid, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic [5:0] Prescale;
  logic       TX_OUT, Busy, Tx_Done;

  int vectors = 0;
  int miscompares = 0;

  bit   exp_tx[$], exp_busy[$], exp_done[$];
  logic obs_tx[$], obs_busy[$], obs_done[$];

  uart_tx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy), .Tx_Done(Tx_Done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Frame as a list of line levels, each stretched to P cycles, then the done cycle.
  function automatic void model_frame(input logic [7:0] data, input bit pen, input bit ptyp,
                                      input int presc);
    bit bits[$];
    int p, ones;
    p = (presc == 0) ? 1 : presc;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pen) bits.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
    for (int i = 0; i < NSTOP; i++) bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c < p; c++) begin
        exp_tx.push_back(bits[b]); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
      end
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
  endfunction

  function automatic void model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
    end
  endfunction

  function automatic void clear_q();
    exp_tx.delete(); exp_busy.delete(); exp_done.delete();
    obs_tx.delete(); obs_busy.delete(); obs_done.delete();
  endfunction

  task automatic sample_cycle();
    @(negedge CLK);
    obs_tx.push_back(TX_OUT); obs_busy.push_back(Busy); obs_done.push_back(Tx_Done);
  endtask

  task automatic start_frame(input logic [7:0] data, input bit pen, input bit ptyp, input int presc);
    @(negedge CLK);
    P_DATA = data; PAR_EN = pen; PAR_TYP = ptyp; Prescale = 6'(presc); Data_Valid = 1'b1;
  endtask

  // Samples n cycles after acceptance, dropping the request after the first one.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      sample_cycle();
      if (i == 0) Data_Valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 0; PAR_TYP = 0; Prescale = '0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Tx_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: tx/busy/done=%b%b%b expected 100", TX_OUT, Busy, Tx_Done);
    end
    RST = 1'b1;
    clear_q();
    model_idle(100);
    repeat (100) sample_cycle();
    for (int i = 0; i < exp_tx.size(); i++) begin
      vectors++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
        miscompares++;
        $display("FAIL idle cyc %0d: tx/busy/done=%b%b%b expected %b%b%b", i,
                 obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_frame_bb();
    bit ref_bits[11] = '{0,1,1,0,1,1,1,0,1,1,1};
    int busy_cnt, done_cnt;
    clear_q();
    model_frame(8'hBB, 1'b1, 1'b1, 8);
    model_idle(3);
    start_frame(8'hBB, 1'b1, 1'b1, 8);
    capture(exp_tx.size());
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      vectors++;
      if (obs_busy[i] === 1'b1) busy_cnt++;
      if (obs_done[i] === 1'b1) done_cnt++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
        miscompares++;
        $display("FAIL frame_bb cyc %0d: tx/busy/done=%b%b%b expected %b%b%b", i,
                 obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
      end
    end
    for (int k = 0; k < 11; k++) begin
      vectors++;
      if (obs_tx[k*8+4] !== ref_bits[k]) begin
        miscompares++;
        $display("FAIL frame_bb_slot %0d: tx=%b expected %b", k, obs_tx[k*8+4], ref_bits[k]);
      end
    end
    vectors++;
    if (busy_cnt != (10 + NSTOP) * 8 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL frame_bb_len: busy=%0d done=%0d expected busy=%0d done=1",
               busy_cnt, done_cnt, (10 + NSTOP) * 8);
    end
  endtask

  task automatic test_parity_cfg();
    int plist[3] = '{8, 16, 32};
    logic [7:0] dec;
    int p;
    for (int mode = 0; mode < 3; mode++)
      for (int pi = 0; pi < 3; pi++) begin
        p = plist[pi];
        clear_q();
        model_frame(8'hBB, mode != 0, mode == 2, p);
        model_idle(2);
        start_frame(8'hBB, mode != 0, mode == 2, p);
        capture(exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++) begin
          vectors++;
          if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
            miscompares++;
            $display("FAIL parity_cfg m%0d p%0d cyc %0d: tx/busy/done=%b%b%b expected %b%b%b",
                     mode, p, i, obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
          end
        end
        // Mid-bit decode, as a receiver with the same prescale would see it.
        for (int k = 0; k < 8; k++) dec[k] = obs_tx[(1 + k) * p + p / 2];
        vectors++;
        if (dec !== 8'hBB) begin
          miscompares++;
          $display("FAIL parity_cfg_decode m%0d p%0d: got %h expected bb", mode, p, dec);
        end
      end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit pen, ptyp;
    int p;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
      p = (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 63 : int'($urandom_range(0, 40));
      clear_q();
      model_frame(d, pen, ptyp, p);
      model_idle(2);
      start_frame(d, pen, ptyp, p);
      capture(exp_tx.size());
      for (int i = 0; i < exp_tx.size(); i++) begin
        vectors++;
        if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
          miscompares++;
          $display("FAIL random d=%h pen=%0d typ=%0d p=%0d cyc %0d: tx/busy/done=%b%b%b expected %b%b%b",
                   d, pen, ptyp, p, i, obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
        end
      end
    end
  endtask

  // Request held high from mid-frame with new data and config: ignored until Tx_Done.
  task automatic test_back_to_back();
    int done_idx;
    clear_q();
    model_frame(8'hBB, 1'b1, 1'b0, 4);
    done_idx = exp_tx.size() - 1;
    model_frame(8'h3C, 1'b0, 1'b1, 5);
    model_idle(2);
    start_frame(8'hBB, 1'b1, 1'b0, 4);
    for (int i = 0; i < exp_tx.size(); i++) begin
      sample_cycle();
      if (i == 0) begin
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b1; Prescale = 6'd5; Data_Valid = 1'b1;
      end
      if (i == done_idx + 1) Data_Valid = 1'b0;
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      vectors++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: tx/busy/done=%b%b%b expected %b%b%b", i,
                 obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
      end
    end
  endtask

  // Reset during data bit 4 (cycles 40..47 at P=8), then a clean frame.
  task automatic test_reset_mid_frame();
    logic [7:0] d;
    clear_q();
    model_frame(8'hBB, 1'b1, 1'b0, 8);
    while (exp_tx.size() > 44) begin
      void'(exp_tx.pop_back()); void'(exp_busy.pop_back()); void'(exp_done.pop_back());
    end
    model_idle(60);
    start_frame(8'hBB, 1'b1, 1'b0, 8);
    for (int i = 0; i < exp_tx.size(); i++) begin
      sample_cycle();
      if (i == 0) Data_Valid = 1'b0;
      if (i == 43) RST = 1'b0;
      if (i == 44) RST = 1'b1;
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      vectors++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: tx/busy/done=%b%b%b expected %b%b%b", i,
                 obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
      end
    end
    d = 8'($urandom);
    clear_q();
    model_frame(d, 1'b1, 1'b1, 6);
    model_idle(2);
    start_frame(d, 1'b1, 1'b1, 6);
    capture(exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      vectors++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i] || obs_done[i] !== exp_done[i]) begin
        miscompares++;
        $display("FAIL after_reset d=%h cyc %0d: tx/busy/done=%b%b%b expected %b%b%b", d, i,
                 obs_tx[i], obs_busy[i], obs_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
      end
    end
  endtask

  initial begin
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = '0;
    test_reset();
    test_frame_bb();
    test_parity_cfg();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
